// File: rtl/alu_seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_multiplier_pkg
// Description : Shared definitions for the sequential ALU multiplier: CPU word
//               width, ALU result-mux selector codes and multiplier FSM states.
// Revision    : 1.0  initial release
// ============================================================================
package alu_seq_multiplier_pkg;

  // CPU data word width
  localparam int CPU_WIDTH = 24;

  // ALU result multiplexer selector codes used by this block's consumer
  localparam logic [2:0] ALU_SEL_AND = 3'b000;
  localparam logic [2:0] ALU_SEL_MUL = 3'b100;
  localparam logic [2:0] ALU_SEL_XOR = 3'b101;

  // Multiplier control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage : alu_seq_multiplier_pkg
`default_nettype wire

// File: rtl/mul_shift_add_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add_datapath
// Description : Radix-2 shift-add core. Holds the 2*WIDTH accumulator, the
//               multiplicand and the multiplier shift register. One conditional
//               add-and-shift per i_step; i_load clears the accumulator and
//               captures new (already non-negative) operands.
// Ports       : clk, rst      clock, asynchronous active-high reset
//               i_load        capture i_mcand/i_mplier, clear accumulator
//               i_step        perform one iteration
//               i_mcand       multiplicand (magnitude)
//               i_mplier      multiplier (magnitude)
//               o_acc         accumulator; unsigned product after WIDTH steps
// Revision    : 1.0  initial release
// ============================================================================
module mul_shift_add_datapath #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     sum;

  // Carry out of the high-half add is kept and shifted into the MSB.
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (i_load) begin
      acc_d    = '0;
      mcand_d  = i_mcand;
      mplier_d = i_mplier;
    end else if (i_step) begin
      acc_d    = {sum, acc_q[WIDTH-1:1]};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign o_acc = acc_q;

endmodule : mul_shift_add_datapath
`default_nettype wire

// File: rtl/alu_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_multiplier
// Description : Fixed-latency sequential signed/unsigned multiplier for the
//               CPU ALU. Start in IDLE captures operands; WIDTH RUN cycles
//               iterate; DONE registers the signed-corrected product and
//               overflow, pulsing Done on the way back to IDLE.
// Ports       : Clock, Reset  clock, asynchronous active-high reset
//               Start         request, accepted only while Ready
//               Signed, A, B  mode and operands, sampled with Start
//               Ready         idle, able to accept Start
//               Busy          operation in flight (RUN or DONE)
//               Done          one-cycle result-valid pulse
//               Product       low product word (ALU MUL input)
//               ProductHi     high product word
//               Overflow      product does not fit WIDTH bits in captured mode
// Revision    : 1.0  initial release
// ============================================================================
module alu_seq_multiplier
  import alu_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] ProductHi,
  output logic             Overflow
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]   product_hi_q, product_hi_d;
  logic               overflow_q, overflow_d;

  logic               dp_load;
  logic               dp_step;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result;

  // Magnitudes in signed mode; -2^(WIDTH-1) maps onto itself, which is the
  // correct unsigned magnitude, so no special case is required.
  assign mcand_in  = (Signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign mplier_in = (Signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

  assign result = neg_q ? (~acc + 1'b1) : acc;

  mul_shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (Clock),
    .rst      (Reset),
    .i_load   (dp_load),
    .i_step   (dp_step),
    .i_mcand  (mcand_in),
    .i_mplier (mplier_in),
    .o_acc    (acc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sgn_d        = sgn_q;
    neg_d        = neg_q;
    done_d       = 1'b0;
    product_d    = product_q;
    product_hi_d = product_hi_q;
    overflow_d   = overflow_q;
    dp_load      = 1'b0;
    dp_step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          dp_load = 1'b1;
          sgn_d   = Signed;
          neg_d   = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        product_d    = result[WIDTH-1:0];
        product_hi_d = result[2*WIDTH-1:WIDTH];
        // Signed fit means the upper word is all copies of the low word's MSB.
        overflow_d   = sgn_q ? (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}})
                             : (result[2*WIDTH-1:WIDTH] != '0);
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sgn_q        <= 1'b0;
      neg_q        <= 1'b0;
      done_q       <= 1'b0;
      product_q    <= '0;
      product_hi_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sgn_q        <= sgn_d;
      neg_q        <= neg_d;
      done_q       <= done_d;
      product_q    <= product_d;
      product_hi_q <= product_hi_d;
      overflow_q   <= overflow_d;
    end
  end

  assign Ready     = (state_q == ST_IDLE);
  assign Busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign Done      = done_q;
  assign Product   = product_q;
  assign ProductHi = product_hi_q;
  assign Overflow  = overflow_q;

endmodule : alu_seq_multiplier
`default_nettype wire

// File: tb/tb_alu_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_multiplier
// Description : Self-checking bench for alu_seq_multiplier: directed vector
//               table, randomized operands against an arithmetic reference,
//               and hand sequences for Start-while-busy, back-to-back and
//               asynchronous reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq_multiplier;

  localparam int W   = 24;
  localparam int LAT = W + 1;   // edges from Start acceptance to Done edge

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sgn_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ready, busy, done, ovf;
  logic [W-1:0] prod, prod_hi;

  int checks = 0;
  int errors = 0;

  alu_seq_multiplier #(.WIDTH(W)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Start     (start),
    .Signed    (sgn_in),
    .A         (a_in),
    .B         (b_in),
    .Ready     (ready),
    .Busy      (busy),
    .Done      (done),
    .Product   (prod),
    .ProductHi (prod_hi),
    .Overflow  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: full-precision integer product of the operands as interpreted
  // in the requested mode.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic ov);
    longint pa, pb, p, lim;
    logic [63:0] pv;
    lim = 64'sd1 <<< (W - 1);
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({40'd0, a});
      pb = longint'({40'd0, b});
    end
    p  = pa * pb;
    pv = p;
    lo = pv[W-1:0];
    hi = pv[2*W-1:W];
    ov = s ? ((p < -lim) || (p >= lim)) : (pv[2*W-1:W] != '0);
  endtask

  logic [W-1:0] r_lo, r_hi, e_lo, e_hi;
  logic         r_ov, e_ov;
  int           lat;

  // Called away from a clock edge; Start is accepted at the next rising edge.
  // Returns just after the edge that raised Done (or after a cycle budget).
  task automatic do_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    sgn_in = s; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sgn_in = 1'($urandom); a_in = W'($urandom); b_in = W'($urandom);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    lat = 0;
    while (lat < 3 * LAT) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    r_lo = prod; r_hi = prod_hi; r_ov = ovf;
  endtask

  // Start a multiply, inject an extra Start pulse after edge k+inj, and count
  // Done pulses over a window; the extra request must be ignored.
  task automatic glitch_test(input string nm, input int inj,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_lo, input logic [W-1:0] held);
    int pulses, first;
    logic [W-1:0] cap;
    pulses = 0; first = 0; cap = '0;
    @(negedge clk);
    sgn_in = 1'b0; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 2 * LAT; i++) begin
      @(posedge clk); #1;
      if (i == inj) begin
        start = 1'b1; a_in = 24'h000002; b_in = 24'h000009;
        chk({nm, "_held_during_run"}, {40'd0, prod}, {40'd0, held});
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (first == 0) begin
          first = i;
          cap = prod;
        end
      end
    end
    chk({nm, "_done_pulses"}, 64'(pulses), 64'd1);
    chk({nm, "_done_edge"}, 64'(first), 64'(LAT));
    chk({nm, "_product"}, {40'd0, cap}, {40'd0, exp_lo});
    chk({nm, "_idle_after"}, {62'd0, ready, busy}, 64'b10);
  endtask

  initial begin
    vecs[0] = '{s: 1'b0, a: 24'h000003, b: 24'h000005, lo: 24'h00000F, hi: 24'h000000, ovf: 1'b0};
    vecs[1] = '{s: 1'b1, a: 24'hFFFFFD, b: 24'h000005, lo: 24'hFFFFF1, hi: 24'hFFFFFF, ovf: 1'b0};
    vecs[2] = '{s: 1'b0, a: 24'hFFFFFF, b: 24'hFFFFFF, lo: 24'h000001, hi: 24'hFFFFFE, ovf: 1'b1};
    vecs[3] = '{s: 1'b1, a: 24'h800000, b: 24'h800000, lo: 24'h000000, hi: 24'h400000, ovf: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {16'd0, prod, prod_hi, 13'd0, ovf, done, busy}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      do_mul(vecs[i].s, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("vec%0d_lo", i), {40'd0, r_lo}, {40'd0, vecs[i].lo});
      chk($sformatf("vec%0d_hi", i), {40'd0, r_hi}, {40'd0, vecs[i].hi});
      chk($sformatf("vec%0d_ovf", i), {63'd0, r_ov}, {63'd0, vecs[i].ovf});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_width", i), {63'd0, done}, 64'd0);
    end

    // Randomized operands with corner-value bias
    for (int i = 0; i < 40; i++) begin
      logic         s;
      logic [W-1:0] a, b;
      s = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       a = 24'h800000;
        1:       a = 24'hFFFFFF;
        2:       a = W'($urandom_range(0, 3));
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       b = 24'h800000;
        1:       b = 24'hFFFFFF;
        2:       b = W'($urandom_range(0, 3));
        default: b = W'($urandom);
      endcase
      model(s, a, b, e_lo, e_hi, e_ov);
      do_mul(s, a, b);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("rnd%0d_result s=%0d a=%h b=%h", i, s, a, b),
          {15'd0, r_ov, r_hi, r_lo}, {15'd0, e_ov, e_hi, e_lo});
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_done_width", i), {63'd0, done}, 64'd0);
    end

    // Seed a known held result, then Start pulses during RUN and during DONE
    @(negedge clk);
    do_mul(1'b0, 24'h000004, 24'h000004);
    chk("seed_product", {40'd0, r_lo}, 64'h10);
    @(negedge clk);
    glitch_test("start_mid_run", 10, 24'h000003, 24'h000005, 24'h00000F, 24'h000010);
    glitch_test("start_in_done", LAT - 1, 24'h000007, 24'h000006, 24'h00002A, 24'h00000F);

    // Back-to-back: second Start accepted in the Done cycle
    @(negedge clk);
    do_mul(1'b0, 24'h000003, 24'h000005);
    chk("b2b_first", {40'd0, r_lo}, 64'h0F);
    chk("b2b_ready_with_done", {62'd0, ready, done}, 64'b11);
    do_mul(1'b1, 24'hFFFFFD, 24'h000005);
    chk("b2b_latency", 64'(lat), 64'(LAT));
    chk("b2b_second", {40'd0, r_hi, r_lo}, 64'hFFFFFF_FFFFF1);

    // Asynchronous reset at iteration 10 of an in-flight multiply
    @(negedge clk);
    sgn_in = 1'b0; a_in = 24'hFFFFFF; b_in = 24'hFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {16'd0, prod, prod_hi, 13'd0, ovf, done, busy}, 64'd0);
    chk("async_reset_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_mul(1'b0, 24'h000007, 24'h000006);
    chk("post_reset_latency", 64'(lat), 64'(LAT));
    chk("post_reset_product", {15'd0, r_ov, r_hi, r_lo}, 64'h2A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_seq_multiplier
`default_nettype wire
